// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen -- per-channel edge detector with stretched output pulses.
//
// Each channel synchronises its level input, detects rising and/or falling
// edges as selected by its mode bits, and stretches every detected edge into
// a pulse of PULSE_LEN clk cycles. An edge that arrives while a pulse is still
// running reloads the length, so the pulse is extended without a low gap.
//
// Parameters
//   CHANNELS    (1..32)  number of independent channels
//   SYNC_STAGES (0..3)   synchroniser flops ahead of edge detection
//   PULSE_LEN   (1..255) pulse length in clk cycles
//
// Ports
//   clk        clock; all state updates on its rising edge
//   reset      asynchronous, active-high reset
//   ref_level  [CHANNELS]   per-channel level inputs, may be asynchronous.
//              Named ref_level because "ref" is a SystemVerilog keyword.
//   mode       [2*CHANNELS] bits [2i+1:2i] for channel i:
//              00 off, 01 rising, 10 falling, 11 both
//   pulse      [CHANNELS]   per-channel pulse, high while the channel counter
//                           is nonzero
//   any_pulse  OR of all pulse bits
//
// Optional feature (macro EDGE_PULSE_OVERRUN_EN):
//   ovr_clr    clears all overrun flags the cycle after it is sampled high
//   overrun    [CHANNELS] sticky flag, set when an edge retriggers a running
//              pulse; a set in the same cycle as a clear wins
module edge_pulse_gen #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   ref_level,
  input  logic [2*CHANNELS-1:0] mode,
`ifdef EDGE_PULSE_OVERRUN_EN
  input  logic                  ovr_clr,
  output logic [CHANNELS-1:0]   overrun,
`endif
  output logic [CHANNELS-1:0]   pulse,
  output logic                  any_pulse
);

  localparam int               CNT_W    = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             s_s;
    logic             prev_r;
    logic             rise_s;
    logic             fall_s;
    logic             detect_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    if (SYNC_STAGES == 0) begin : g_nosync
      // Without synchroniser the input feeds edge detection directly.
      assign s_s = ref_level[i];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_r;

      // Synchroniser shift chain; bit 0 samples the raw input.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_r <= '0;
        end else begin
          sync_r[0] <= ref_level[i];
          for (int j = 1; j < SYNC_STAGES; j++) begin
            sync_r[j] <= sync_r[j-1];
          end
        end
      end

      assign s_s = sync_r[SYNC_STAGES-1];
    end

    // Edge detection, mode selection and counter next-state.
    always_comb begin
      rise_s     = 1'b0;
      fall_s     = 1'b0;
      detect_s   = 1'b0;
      cnt_next_s = cnt_r;
      rise_s     = s_s & ~prev_r;
      fall_s     = ~s_s & prev_r;
      case (mode[2*i +: 2])
        2'b01:   detect_s = rise_s;
        2'b10:   detect_s = fall_s;
        2'b11:   detect_s = rise_s | fall_s;
        default: detect_s = 1'b0;
      endcase
      // A detection always reloads, which is what extends a running pulse.
      if (detect_s) begin
        cnt_next_s = LOAD_VAL;
      end else if (cnt_r != CNT_ZERO) begin
        cnt_next_s = cnt_r - CNT_ONE;
      end else begin
        cnt_next_s = CNT_ZERO;
      end
    end

    // History flop and pulse counter. prev resets to 0 so a level that is
    // already high when reset releases is seen as a rising edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prev_r <= 1'b0;
        cnt_r  <= CNT_ZERO;
      end else begin
        prev_r <= s_s;
        cnt_r  <= cnt_next_s;
      end
    end

    assign pulse[i] = (cnt_r != CNT_ZERO);

`ifdef EDGE_PULSE_OVERRUN_EN
    logic ovr_r;
    logic retrig_s;

    assign retrig_s = detect_s & (cnt_r != CNT_ZERO);

    // Sticky overrun flag; a retrigger in the clearing cycle keeps it set.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ovr_r <= 1'b0;
      end else if (retrig_s) begin
        ovr_r <= 1'b1;
      end else if (ovr_clr) begin
        ovr_r <= 1'b0;
      end else begin
        ovr_r <= ovr_r;
      end
    end

    assign overrun[i] = ovr_r;
`endif
  end

  assign any_pulse = |pulse;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Testbench for edge_pulse_gen. Three instances with different
// synchroniser depth / pulse length share the same inputs; each is checked
// every cycle against a reference model that keeps the history of sampled
// input vectors and derives the visible level, edges and remaining pulse
// time from it.
module tb_edge_pulse_gen;
  localparam int NCH  = 4;
  localparam int NCFG = 3;

  logic             clk;
  logic             reset;
  logic [NCH-1:0]   ref_level;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]   pulse_a, pulse_b, pulse_c;
  logic             any_a, any_b, any_c;
`ifdef EDGE_PULSE_OVERRUN_EN
  logic             ovr_clr;
  logic [NCH-1:0]   ovr_a, ovr_b, ovr_c;
`endif

  int tests_run = 0;
  int fails     = 0;

  // Reference model state
  logic [NCH-1:0] hist[$];            // input vector sampled at each edge since reset
  int             rem [NCFG][NCH];    // remaining pulse cycles
  logic [NCH-1:0] ovr_exp [NCFG];

  edge_pulse_gen #(.CHANNELS(NCH), .SYNC_STAGES(2), .PULSE_LEN(1)) dut_a (
    .clk(clk), .reset(reset), .ref_level(ref_level), .mode(mode),
`ifdef EDGE_PULSE_OVERRUN_EN
    .ovr_clr(ovr_clr), .overrun(ovr_a),
`endif
    .pulse(pulse_a), .any_pulse(any_a));

  edge_pulse_gen #(.CHANNELS(NCH), .SYNC_STAGES(0), .PULSE_LEN(4)) dut_b (
    .clk(clk), .reset(reset), .ref_level(ref_level), .mode(mode),
`ifdef EDGE_PULSE_OVERRUN_EN
    .ovr_clr(ovr_clr), .overrun(ovr_b),
`endif
    .pulse(pulse_b), .any_pulse(any_b));

  edge_pulse_gen #(.CHANNELS(NCH), .SYNC_STAGES(1), .PULSE_LEN(8)) dut_c (
    .clk(clk), .reset(reset), .ref_level(ref_level), .mode(mode),
`ifdef EDGE_PULSE_OVERRUN_EN
    .ovr_clr(ovr_clr), .overrun(ovr_c),
`endif
    .pulse(pulse_c), .any_pulse(any_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int s_of(input int c);
    case (c)
      0:       return 2;
      1:       return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int p_of(input int c);
    case (c)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  // Level visible to edge detection at edge k: the input sampled S edges earlier.
  function automatic logic seen(input int c, input int ch, input int k);
    if (k < s_of(c)) return 1'b0;
    return hist[k - s_of(c)][ch];
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int c = 0; c < NCFG; c++) begin
      ovr_exp[c] = '0;
      for (int ch = 0; ch < NCH; ch++) rem[c][ch] = 0;
    end
  endtask

  task automatic model_edge();
    int       k;
    logic     now_l, before_l, hit, retrig;
    logic [1:0] md;
    if (reset) begin
      model_reset();
      return;
    end
    hist.push_back(ref_level);
    k = hist.size() - 1;
    for (int c = 0; c < NCFG; c++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        now_l    = seen(c, ch, k);
        before_l = (k >= 1) ? seen(c, ch, k - 1) : 1'b0;
        md       = mode[2*ch +: 2];
        hit      = (now_l != before_l) &&
                   ((md == 2'b11) || (md == 2'b01 && now_l) || (md == 2'b10 && !now_l));
        retrig   = hit && (rem[c][ch] != 0);
        if (hit) rem[c][ch] = p_of(c);
        else if (rem[c][ch] > 0) rem[c][ch] = rem[c][ch] - 1;
`ifdef EDGE_PULSE_OVERRUN_EN
        if (retrig) ovr_exp[c][ch] = 1'b1;
        else if (ovr_clr) ovr_exp[c][ch] = 1'b0;
`endif
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [NCH-1:0] exp_p, obs_p;
    logic           obs_any;
`ifdef EDGE_PULSE_OVERRUN_EN
    logic [NCH-1:0] obs_o;
`endif
    for (int c = 0; c < NCFG; c++) begin
      exp_p = '0;
      for (int ch = 0; ch < NCH; ch++) exp_p[ch] = (rem[c][ch] != 0);
      case (c)
        0:       begin obs_p = pulse_a; obs_any = any_a; end
        1:       begin obs_p = pulse_b; obs_any = any_b; end
        default: begin obs_p = pulse_c; obs_any = any_c; end
      endcase
      tests_run++;
      assert (obs_p === exp_p) else begin
        fails++;
        $error("FAIL %s cfg%0d pulse observed=%b expected=%b", tag, c, obs_p, exp_p);
      end
      tests_run++;
      assert (obs_any === (|exp_p)) else begin
        fails++;
        $error("FAIL %s cfg%0d any_pulse observed=%b expected=%b", tag, c, obs_any, |exp_p);
      end
`ifdef EDGE_PULSE_OVERRUN_EN
      case (c)
        0:       obs_o = ovr_a;
        1:       obs_o = ovr_b;
        default: obs_o = ovr_c;
      endcase
      tests_run++;
      assert (obs_o === ovr_exp[c]) else begin
        fails++;
        $error("FAIL %s cfg%0d overrun observed=%b expected=%b", tag, c, obs_o, ovr_exp[c]);
      end
`endif
    end
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
    end
  endtask

  initial begin
    reset     = 1'b0;
    ref_level = 4'b0000;
    mode      = 8'h00;
`ifdef EDGE_PULSE_OVERRUN_EN
    ovr_clr   = 1'b0;
`endif
    model_reset();
    #1 reset = 1'b1;
    #1 check_all("reset_async");
    run(3, "reset_hold");

    // Levels already high across reset release: ch0 rising-only pulses once,
    // ch1 falling-only stays quiet.
    ref_level = 4'b0011;
    mode      = 8'b0000_1001;
    run(1, "reset_hold_hi");
    reset = 1'b0;
    run(12, "release_hi");

    // Rising-only: pulse on 0->1, none on 1->0.
    ref_level = 4'b0000;
    mode      = 8'b0101_0101;
    run(6, "rise_idle");
    ref_level[0] = 1'b1;
    run(6, "rise_edge");
    ref_level[0] = 1'b0;
    run(6, "rise_fall_ignored");

    // Falling-only with a retrigger two cycles after the first fall.
    mode         = 8'b1010_1010;
    ref_level[1] = 1'b1;
    run(6, "fall_setup");
    ref_level[1] = 1'b0;
    run(1, "fall_first");
    ref_level[1] = 1'b1;
    run(1, "fall_between");
    ref_level[1] = 1'b0;
    run(10, "fall_retrig");
`ifdef EDGE_PULSE_OVERRUN_EN
    ovr_clr = 1'b1;
    run(1, "ovr_clear");
    ovr_clr = 1'b0;
    run(2, "ovr_cleared");
`endif

    // Both edges, ch2 toggling every cycle, then static.
    mode = 8'hFF;
    run(6, "both_idle");
    for (int t = 0; t < 10; t++) begin
      ref_level[2] = ~ref_level[2];
      run(1, "both_toggle");
    end
    run(12, "both_tail");

    // Reset in the middle of a long pulse on ch3, input then static low.
    ref_level[3] = 1'b1;
    run(12, "mid_setup");
    ref_level[3] = 1'b0;
    run(4, "mid_pulse");
    reset = 1'b1;
    model_reset();
    #1 check_all("mid_reset_async");
    run(2, "mid_reset_hold");
    reset = 1'b0;
    run(12, "mid_after_release");

    // Random modes and levels.
    for (int t = 0; t < 300; t++) begin
      if (t % 25 == 0) mode = 8'($urandom);
      ref_level = 4'($urandom);
`ifdef EDGE_PULSE_OVERRUN_EN
      ovr_clr = 1'($urandom_range(0, 7) == 0);
`endif
      run(1, "random");
    end

    // All channels off with random inputs.
    mode = 8'h00;
    for (int t = 0; t < 60; t++) begin
      ref_level = 4'($urandom);
      run(1, "mode_off");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
